dram_arbiter: RTL

Shares the single external DRAM read port between up to N_REQ on-chip requesters: the split prefetcher, SFTM coefficient fetch and DPM reference fetch. It grants one transaction at a time in round-robin order and drives the dram_req/addr/len/ack handshake. It counts returned beats and steers each beat to its owner. It also flags protocol errors and timeouts to the global controller.

---
 rtl/dram_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM read port between N_REQ requesters.
// Steers returned beats to the owner and reports protocol errors and timeouts.
module dram_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic                    resp_last,
    output logic [DATA_W-1:0]       resp_data,
    output logic [N_REQ-1:0]        done,
    output logic                    dram_req,
    output logic [ADDR_W-1:0]       dram_addr,
    output logic [LEN_W-1:0]        dram_len,
    input  logic                    dram_ack,
    input  logic                    dram_data_valid,
    input  logic [DATA_W-1:0]       dram_data_in,
    input  logic                    err_clr,
    output logic                    busy,
    output logic                    error,
    output logic [1:0]              err_code
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     rr_next;
    logic              gnt_any;
    logic              grant;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  gnt_len;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] gnt_addr;
    logic [TW-1:0]     timer;
    logic [N_REQ-1:0]  done_q;
    logic [N_REQ-1:0]  owner_oh;
    logic              beat;
    logic              last_beat;
    logic              tmo;
    logic              stray;
    logic              zlen;
    logic              new_err;
    logic [1:0]        new_code;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        int j;
        gnt_any = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!gnt_any && req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    assign gnt_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign gnt_len   = req_len[int'(gnt_idx)*LEN_W +: LEN_W];
    assign rr_next   = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    assign owner_oh  = ONE << owner;

    assign grant     = (state == S_IDLE) && gnt_any;
    assign zlen      = grant && (gnt_len == '0);
    assign beat      = (state == S_DATA) && dram_data_valid;
    assign last_beat = beat && (cnt == LEN_W'(1));
    assign stray     = dram_data_valid && (state != S_DATA);
    assign tmo       = (((state == S_REQ) && !dram_ack) ||
                        ((state == S_DATA) && !dram_data_valid)) &&
                       (timer == TW'(TIMEOUT - 1));

    assign new_err   = tmo || stray || zlen;
    assign new_code  = tmo ? 2'd1 : (stray ? 2'd2 : 2'd3);

    assign req_ready  = grant ? (ONE << gnt_idx) : '0;
    assign resp_valid = beat ? owner_oh : '0;
    assign resp_last  = last_beat;
    assign resp_data  = beat ? dram_data_in : '0;
    assign done       = done_q;
    assign dram_req   = (state == S_REQ);
    assign dram_addr  = addr_q;
    assign dram_len   = len_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            len_q  <= '0;
            addr_q <= '0;
            timer  <= '0;
            done_q <= '0;
        end else begin
            done_q <= '0;
            unique case (state)
                S_IDLE: begin
                    if (grant) begin
                        owner  <= gnt_idx;
                        rr_ptr <= rr_next;
                        addr_q <= gnt_addr;
                        len_q  <= gnt_len;
                        timer  <= '0;
                        if (zlen) done_q <= ONE << gnt_idx;
                        else      state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dram_ack) begin
                        state <= S_DATA;
                        cnt   <= len_q;
                        timer <= '0;
                    end else if (tmo) begin
                        state  <= S_IDLE;
                        done_q <= owner_oh;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        timer <= '0;
                        cnt   <= cnt - 1'b1;
                        if (last_beat) begin
                            state  <= S_IDLE;
                            done_q <= owner_oh;
                        end
                    end else if (tmo) begin
                        state  <= S_IDLE;
                        done_q <= owner_oh;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A clear coinciding with a new error leaves the new cause latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error    <= 1'b0;
            err_code <= 2'd0;
        end else if (new_err) begin
            error <= 1'b1;
            if (!error || err_clr) err_code <= new_code;
        end else if (err_clr) begin
            error    <= 1'b0;
            err_code <= 2'd0;
        end
    end

endmodule
